obi_mem_arbiter: RTL



---
 rtl/obi_mem_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/obi_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : obi_mem_arbiter
// Description : Round-robin 2:1 OBI arbiter (instr/data -> one memory port)
//               with request locking and an in-order owner FIFO for rvalid.
// Revision    : 1.0
// ============================================================================
module obi_mem_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,

    input  logic                                   instr_req_i,
    input  logic [ADDR_WIDTH-1:0]                  instr_addr_i,
    output logic                                   instr_gnt_o,
    output logic                                   instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]                  instr_rdata_o,

    input  logic                                   data_req_i,
    input  logic                                   data_we_i,
    input  logic [DATA_WIDTH/8-1:0]                data_be_i,
    input  logic [ADDR_WIDTH-1:0]                  data_addr_i,
    input  logic [DATA_WIDTH-1:0]                  data_wdata_i,
    output logic                                   data_gnt_o,
    output logic                                   data_rvalid_o,
    output logic [DATA_WIDTH-1:0]                  data_rdata_o,

    output logic                                   mem_req_o,
    output logic                                   mem_we_o,
    output logic [DATA_WIDTH/8-1:0]                mem_be_o,
    output logic [ADDR_WIDTH-1:0]                  mem_addr_o,
    output logic [DATA_WIDTH-1:0]                  mem_wdata_o,
    input  logic                                   mem_gnt_i,
    input  logic                                   mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                  mem_rdata_i,

    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   protocol_err_o
);

    localparam int c_CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int c_PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(MAX_OUTSTANDING);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(MAX_OUTSTANDING - 1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } lock_state_t;

    lock_state_t                r_state;
    lock_state_t                w_state_nxt;
    logic                       r_lock_owner;
    logic                       w_lock_owner_nxt;
    logic                       r_last_grant;
    logic [MAX_OUTSTANDING-1:0] r_owner;
    logic [c_PTR_W-1:0]         r_wptr;
    logic [c_PTR_W-1:0]         r_rptr;
    logic [c_CNT_W-1:0]         r_count;
    logic                       r_perr;

    logic w_sel;        // 0 = instr, 1 = data
    logic w_sel_req;
    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_head;

    assign w_full  = (r_count == c_CNT_FULL);
    assign w_empty = (r_count == '0);
    assign w_head  = r_owner[r_rptr];

    always_comb begin
        w_sel = 1'b0;
        if (r_state == S_LOCKED) begin
            w_sel = r_lock_owner;
        end else if (instr_req_i && data_req_i) begin
            w_sel = ~r_last_grant;
        end else if (data_req_i) begin
            w_sel = 1'b1;
        end
    end

    assign w_sel_req   = w_sel ? data_req_i : instr_req_i;
    assign mem_req_o   = w_sel_req && !w_full;
    assign mem_addr_o  = w_sel ? data_addr_i  : instr_addr_i;
    assign mem_we_o    = w_sel && data_we_i;
    assign mem_be_o    = w_sel ? data_be_i    : '1;
    assign mem_wdata_o = w_sel ? data_wdata_i : '0;

    assign w_push      = mem_gnt_i && mem_req_o;
    assign instr_gnt_o = w_push && !w_sel;
    assign data_gnt_o  = w_push && w_sel;

    // Responses arriving with no owner recorded are dropped, not routed.
    assign w_pop          = mem_rvalid_i && !w_empty;
    assign instr_rvalid_o = w_pop && !w_head;
    assign data_rvalid_o  = w_pop && w_head;
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;

    assign outstanding_o  = r_count;
    assign protocol_err_o = r_perr;

    always_comb begin
        w_state_nxt      = r_state;
        w_lock_owner_nxt = r_lock_owner;
        case (r_state)
            S_IDLE: begin
                if (mem_req_o && !mem_gnt_i) begin
                    w_state_nxt      = S_LOCKED;
                    w_lock_owner_nxt = w_sel;
                end
            end
            S_LOCKED: begin
                if (mem_gnt_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_IDLE;
            r_lock_owner <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_lock_owner <= w_lock_owner_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_last_grant <= 1'b0;
            r_owner      <= '0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_perr       <= 1'b0;
        end else begin
            if (w_push) begin
                r_owner[r_wptr] <= w_sel;
                r_last_grant    <= w_sel;
                r_wptr          <= (r_wptr == c_PTR_LAST) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_PTR_LAST) ? '0 : r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (mem_rvalid_i && w_empty) begin
                r_perr <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
